sub_array_loader: RTL and testbench
===================================

SUB_ARRAY_LOADER -- requirements
Module: sub_array_loader

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4, element width in bits.
REQ-002 SHALL have parameter ROWS, default 8, array rows.
REQ-003 SHALL have parameter COLS, default 8, array columns.
REQ-004 SHALL have parameter SUB_ROWS, default 4, rows in leading sub-array region; legal range 1..ROWS.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_data, input, BIT_WIDTH, one element per transfer.
REQ-008 SHALL have port in_valid, input, 1, in_data valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts an element.
REQ-010 SHALL have port flush, input, 1, abort current fill and restart.
REQ-011 SHALL have port out, output, [BIT_WIDTH-1:0] out[ROWS][COLS], assembled array, registered.
REQ-012 SHALL have port out_valid, output, 1, out holds a complete array.
REQ-013 SHALL have port out_ready, input, 1, consumer takes the array.
REQ-014 SHALL have port fill_count, output, $clog2(ROWS*COLS+1), elements accepted in current fill.

Function
REQ-015 SHALL implement a two-state FSM: FILL (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-016 SHALL write in_data into the storage slot of element index k (k = fill_count) on each cycle with in_valid && in_ready.
REQ-017 SHALL map k < COLS*SUB_ROWS to row k%SUB_ROWS, column k/SUB_ROWS (region A, column-major over rows 0..SUB_ROWS-1).
REQ-018 SHALL map k >= COLS*SUB_ROWS to row SUB_ROWS+(k')%(ROWS-SUB_ROWS), column k'/(ROWS-SUB_ROWS), where k' = k-COLS*SUB_ROWS (region B).
REQ-019 SHALL derive row, column and region from incrementing counters, with no divider or multiplier on the write path.
REQ-020 SHALL wrap row counter to 0 and increment column at the region row limit; at end of last column of region A, switch to region B with row=SUB_ROWS, col=0.
REQ-021 SHALL skip region B entirely when SUB_ROWS == ROWS; last element is then k = COLS*ROWS-1 in region A.
REQ-022 SHALL, on acceptance of element ROWS*COLS-1, transition FILL->FULL; out_valid SHALL assert in the following cycle with the final element visible in out.
REQ-023 SHALL hold out and out_valid stable in FULL until out_valid && out_ready; in that cycle SHALL return to FILL with counters at 0, and in_ready SHALL be 1 on the next cycle (no overlapped fill).
REQ-024 SHALL ignore in_valid while in FULL; no storage change.
REQ-025 SHALL, on flush=1 in either state, return to FILL with counters and fill_count = 0 next cycle, discarding any same-cycle transfer; storage contents are not cleared.
REQ-026 SHALL give flush priority over in_valid and out_ready in the same cycle.
REQ-027 SHALL leave out contents unchanged by out_ready handshake; stale values remain until overwritten.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, enter FILL, clear row/col/region counters and fill_count to 0, drive out_valid=0, and clear every out element to 0.
REQ-029 SHALL give rst priority over flush, in_valid and out_ready; reset mid-fill discards all accepted elements.

Verification
REQ-030 SHALL pass fill with defaults: 64 transfers, value = k mod 16, continuous valid -> out_valid at cycle after 64th; out[0][0]=0, out[3][0]=3, out[0][1]=4, out[4][0]=0, out[5][2]=9, out[7][7]=15.
REQ-031 SHALL pass backpressure: out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0, out unchanged, fill_count=64; out_ready=1 -> FILL next cycle, fill_count=0.
REQ-032 SHALL pass flush mid-fill: flush after 20 transfers -> fill_count=0; next 64 transfers land per REQ-017/018 with out[0][0] = first post-flush element.
REQ-033 SHALL pass SUB_ROWS=ROWS=4, COLS=2: 8 transfers values 0..7 -> out[i][j] = j*4+i, out_valid after 8th.
REQ-034 SHALL pass reset during FULL: rst=1 one cycle -> out_valid=0, all out elements 0, in_ready=1.
REQ-035 SHALL pass gapped input: in_valid toggling every cycle -> same array as REQ-030, out_valid after 64 accepted transfers only.

Source files
------------

// File: rtl/sub_array_loader.sv
// sub_array_loader
//   Assembles a stream of elements into a ROWS x COLS array.
//   Elements fill two regions:
//     region A: rows 0..SUB_ROWS-1, column-major (row advances fastest)
//     region B: rows SUB_ROWS..ROWS-1, column-major
//   When the array is complete it is presented on out with out_valid until
//   the consumer takes it (out_ready). Then the next fill starts.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (clears storage as well)
//   in_data    one element per accepted transfer
//   in_valid   in_data is valid
//   in_ready   block accepts an element (high while filling)
//   flush      abort current fill, restart at element 0 (storage kept)
//   out        assembled array, registered
//   out_valid  out holds a complete array
//   out_ready  consumer takes the array
//   fill_count elements accepted in the current fill
module sub_array_loader #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SUB_ROWS  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BIT_WIDTH-1:0]              in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              flush,
  output logic [BIT_WIDTH-1:0]              out [ROWS][COLS],
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(ROWS*COLS+1)-1:0]    fill_count
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int FCW = $clog2(ROWS*COLS+1);

  localparam logic [FCW-1:0] LAST_K      = FCW'(ROWS*COLS-1);
  localparam logic [RW-1:0]  A_ROW_LAST  = RW'(SUB_ROWS-1);
  // Only meaningful when region B exists; kept in range otherwise.
  localparam logic [RW-1:0]  B_ROW_FIRST = RW'((SUB_ROWS < ROWS) ? SUB_ROWS : 0);
  localparam logic [RW-1:0]  B_ROW_LAST  = RW'(ROWS-1);
  localparam logic [CW-1:0]  COL_LAST    = CW'(COLS-1);

  typedef enum logic {FILL, FULL} state_t;

  state_t          state_reg;
  logic [RW-1:0]   row_reg;
  logic [CW-1:0]   col_reg;
  logic            region_b_reg;
  logic [FCW-1:0]  fill_count_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;

  logic            accept;
  logic            row_wrap;

  // flush kills a same-cycle transfer; in_ready_reg is low in FULL.
  assign accept   = in_valid && in_ready_reg && !flush;
  assign row_wrap = region_b_reg ? (row_reg == B_ROW_LAST) : (row_reg == A_ROW_LAST);

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign fill_count = fill_count_reg;

  // Control FSM and write-address counters.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_reg      <= FILL;
      row_reg        <= '0;
      col_reg        <= '0;
      region_b_reg   <= 1'b0;
      fill_count_reg <= '0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            fill_count_reg <= fill_count_reg + 1'b1;
            if (fill_count_reg == LAST_K) begin
              // Final element written this cycle; present array next cycle.
              state_reg     <= FULL;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              row_reg       <= '0;
              col_reg       <= '0;
              region_b_reg  <= 1'b0;
            end else if (!row_wrap) begin
              row_reg <= row_reg + 1'b1;
            end else if (!region_b_reg && col_reg == COL_LAST) begin
              // End of region A: continue at the top-left of region B.
              region_b_reg <= 1'b1;
              row_reg      <= B_ROW_FIRST;
              col_reg      <= '0;
            end else begin
              row_reg <= region_b_reg ? B_ROW_FIRST : '0;
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state_reg      <= FILL;
            fill_count_reg <= '0;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

  // Array storage: written at the counter address, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          out[r][c] <= '0;
        end
      end
    end else if (accept) begin
      out[row_reg][col_reg] <= in_data;
    end
  end

endmodule

// File: tb/tb_sub_array_loader.sv
module tb_sub_array_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [3:0] out_arr [8][8];
  logic       out_valid;
  logic       out_ready;
  logic [6:0] fill_count;

  // SUB_ROWS == ROWS = 4, COLS = 2 instance
  logic [3:0] d2_in_data;
  logic       d2_in_valid;
  logic       d2_in_ready;
  logic       d2_flush;
  logic [3:0] d2_out [4][2];
  logic       d2_out_valid;
  logic       d2_out_ready;
  logic [3:0] d2_fill_count;

  sub_array_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out(out_arr), .out_valid(out_valid),
    .out_ready(out_ready), .fill_count(fill_count)
  );

  sub_array_loader #(.BIT_WIDTH(4), .ROWS(4), .COLS(2), .SUB_ROWS(4)) dut2 (
    .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .flush(d2_flush), .out(d2_out), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .fill_count(d2_fill_count)
  );

  typedef struct {
    int         r;
    int         c;
    logic [3:0] v;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model [8][8];
  int         errors = 0;
  int         checks = 0;
  int         acc_k  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Element index -> (row, col) straight from the region definitions.
  task automatic map_k(input int k, output int r, output int c);
    int kp;
    if (k < 8*4) begin
      r = k % 4;
      c = k / 4;
    end else begin
      kp = k - 8*4;
      r = 4 + kp % 4;
      c = kp / 4;
    end
  endtask

  // One cycle with in_valid high; scoreboard entry only if it was accepted.
  task automatic xfer(input logic [3:0] v);
    logic was_ready;
    int   r, c;
    exp_t e;
    in_data   = v;
    in_valid  = 1'b1;
    was_ready = in_ready && !flush;
    @(posedge clk); #1;
    if (was_ready) begin
      map_k(acc_k, r, c);
      e.r = r; e.c = c; e.v = v;
      sb.push_back(e);
      model[r][c] = v;
      acc_k++;
      chk("fill_count", fill_count, acc_k);
    end
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    int   n;
    n = sb.size();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag, out_arr[e.r][e.c], e.v);
    end
    $display("array %s: %0d elements compared, errors so far %0d", tag, n, errors);
  endtask

  task automatic check_model(input string tag);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk(tag, out_arr[r][c], model[r][c]);
  endtask

  // 64 accepted transfers of (k*mult+base) mod 16; gapped inserts idle cycles.
  task automatic fill64(input int base, input int mult, input bit gapped);
    for (int k = 0; k < 64; k++) begin
      if (gapped) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (k == 63) begin
        chk("out_valid_before_last", out_valid, 1'b0);
        chk("in_ready_before_last", in_ready, 1'b1);
      end
      xfer(4'((k*mult + base) % 16));
    end
    in_valid = 1'b0;
    chk("out_valid_after_last", out_valid, 1'b1);
    chk("in_ready_after_last", in_ready, 1'b0);
    chk("fill_count_full", fill_count, 64);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc_k = 0;
    chk("hs_out_valid", out_valid, 1'b0);
    chk("hs_in_ready", in_ready, 1'b1);
    chk("hs_fill_count", fill_count, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    d2_in_data = '0; d2_in_valid = 1'b0; d2_flush = 1'b0; d2_out_ready = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        model[r][c] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_fill_count", fill_count, 0);
    chk("rst_out00", out_arr[0][0], 0);
    $display("reset done");

    // Continuous fill, value = k mod 16
    fill64(0, 1, 1'b0);
    chk("fill_out00", out_arr[0][0], 0);
    chk("fill_out30", out_arr[3][0], 3);
    chk("fill_out01", out_arr[0][1], 4);
    chk("fill_out40", out_arr[4][0], 0);
    chk("fill_out52", out_arr[5][2], 9);
    chk("fill_out77", out_arr[7][7], 15);
    check_sb("continuous");

    // Backpressure with in_valid held high
    in_valid = 1'b1; in_data = 4'hA;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_fill_count", fill_count, 64);
    end
    check_model("bp_hold");
    handshake();
    in_valid = 1'b0;
    check_model("bp_after_handshake");
    $display("backpressure done");

    // Flush after 20 transfers; same-cycle transfer is discarded
    for (int k = 0; k < 20; k++) xfer(4'((k + 5) % 16));
    in_valid = 1'b0;
    chk("pre_flush_count", fill_count, 20);
    sb.delete();
    flush = 1'b1; in_valid = 1'b1; in_data = 4'h7;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    acc_k = 0;
    chk("flush_fill_count", fill_count, 0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    fill64(1, 3, 1'b0);
    chk("flush_out00", out_arr[0][0], 1);
    check_sb("post_flush");

    // Flush while FULL: back to FILL, storage retained
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    acc_k = 0;
    chk("flush_full_out_valid", out_valid, 1'b0);
    chk("flush_full_in_ready", in_ready, 1'b1);
    chk("flush_full_count", fill_count, 0);
    check_model("flush_full_storage");
    $display("flush done");

    // Gapped input, same values as the continuous fill
    fill64(0, 1, 1'b1);
    chk("gap_out52", out_arr[5][2], 9);
    chk("gap_out77", out_arr[7][7], 15);
    check_sb("gapped");

    // Reset while FULL
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstfull_out_valid", out_valid, 1'b0);
    chk("rstfull_in_ready", in_ready, 1'b1);
    chk("rstfull_count", fill_count, 0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk("rstfull_out", out_arr[r][c], 0);
    $display("reset during FULL done");

    // SUB_ROWS == ROWS instance: 8 transfers 0..7
    for (int k = 0; k < 8; k++) begin
      if (k == 7) chk("d2_out_valid_before", d2_out_valid, 1'b0);
      d2_in_data = 4'(k); d2_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    d2_in_valid = 1'b0;
    chk("d2_out_valid", d2_out_valid, 1'b1);
    chk("d2_fill_count", d2_fill_count, 8);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++)
        chk("d2_out", d2_out[i][j], j*4 + i);
    $display("single-region array done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
